// File: rtl/prog_updown_counter_if.sv
// prog_updown_counter_if
//   Control/status bundle for prog_updown_counter.
//   Control (master -> slave): en, load, load_val, dir, mode, max_val.
//   Status  (slave -> master): count, tc, done, cur_dir.
//   WIDTH must match the WIDTH of the counter instance it is bound to.
interface prog_updown_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             cur_dir;

    modport master (
        output en, load, load_val, dir, mode, max_val,
        input  count, tc, done, cur_dir
    );

    modport slave (
        input  en, load, load_val, dir, mode, max_val,
        output count, tc, done, cur_dir
    );
endinterface

// File: rtl/prog_updown_counter.sv
// prog_updown_counter
//   Programmable up/down counter with wrap, one-shot and bounce modes,
//   registered terminal-count pulse and sticky one-shot done flag.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - prog_updown_counter_if.slave:
//            en, load, load_val, dir, mode, max_val in;
//            count, tc, done, cur_dir out
//   Parameters: WIDTH, RESET_VAL (masked to WIDTH), PRESCALE (1..256).
//   Optional macro UDC_PRESCALE_EN: when defined, a step is taken only
//   once every PRESCALE enabled cycles; otherwise every enabled edge steps.
module prog_updown_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 255,
    parameter int unsigned PRESCALE  = 4
) (
    input logic                  clk,
    input logic                  rst,
    prog_updown_counter_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    if (PRESCALE < 1 || PRESCALE > 256) begin : g_prescale_range
        $error("prog_updown_counter: PRESCALE must be in 1..256");
    end

    mode_e            mode;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             done_q;
    logic             bdir_q;
    logic             cur_dir;
    logic             at_term;
    logic             step_tick;
    logic [WIDTH-1:0] load_clamped;

    assign mode    = mode_e'(bus.mode);
    assign cur_dir = (mode == MODE_BOUNCE) ? bdir_q : bus.dir;

    // Up terminal uses >= so a count stranded above a lowered max_val
    // is treated as terminal on its next step.
    assign at_term = cur_dir ? (count_q == '0) : (count_q >= bus.max_val);

    assign load_clamped = (bus.load_val < bus.max_val) ? bus.load_val : bus.max_val;

`ifdef UDC_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q;

    assign step_tick = (ps_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else if (bus.load) begin
            ps_q <= '0;
        end else if (bus.en) begin
            ps_q <= step_tick ? '0 : ps_q + PS_W'(1);
        end
    end
`else
    assign step_tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_COUNT;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            bdir_q  <= 1'b1;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                count_q <= load_clamped;
                done_q  <= 1'b0;
                bdir_q  <= bus.dir;
            end else if (bus.en && step_tick && !done_q) begin
                if (!at_term) begin
                    count_q <= cur_dir ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                end else begin
                    tc_q <= 1'b1;
                    case (mode)
                        MODE_ONESHOT: begin
                            done_q <= 1'b1;
                        end
                        MODE_BOUNCE: begin
                            bdir_q <= ~bdir_q;
                            // Reversing from the top steps to max_val-1 rather than
                            // count-1 so a stranded count above max_val cannot survive.
                            if (bus.max_val == '0) begin
                                count_q <= '0;
                            end else if (cur_dir) begin
                                count_q <= WIDTH'(1);
                            end else begin
                                count_q <= bus.max_val - WIDTH'(1);
                            end
                        end
                        default: begin
                            count_q <= cur_dir ? bus.max_val : '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.done    = done_q;
    assign bus.cur_dir = cur_dir;
endmodule

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter
//   Directed scenarios plus a randomized run checked against an
//   arithmetic reference model of the counter rules.
//   Build with UDC_PRESCALE_EN defined to exercise the step divider.
module tb_prog_updown_counter;
    localparam int unsigned W  = 8;
    localparam int unsigned PS = 4;
`ifdef UDC_PRESCALE_EN
    localparam int P = PS;
`else
    localparam int P = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int m_count;
    int m_tc;
    int m_done;
    int m_bdir;
    int m_ps;

    prog_updown_counter_if #(.WIDTH(W)) bus ();

    prog_updown_counter #(
        .WIDTH    (W),
        .RESET_VAL(255),
        .PRESCALE (PS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Applies one clock edge worth of the counter rules to the model.
    function automatic void model_edge(input int ld, input int ldv, input int en,
                                       input int dir, input int mode, input int mx);
        int cdir;
        int take;
        bit term;
        cdir = (mode == 2) ? m_bdir : dir;
        take = 0;
        m_tc = 0;
        if (ld != 0) begin
            m_count = (ldv < mx) ? ldv : mx;
            m_done  = 0;
            m_bdir  = dir;
            m_ps    = 0;
        end else if (en != 0) begin
            m_ps = m_ps + 1;
            if (m_ps == P) begin
                m_ps = 0;
                take = 1;
            end
        end
        if (take != 0 && m_done == 0) begin
            term = (cdir != 0) ? (m_count == 0) : (m_count >= mx);
            if (!term) begin
                m_count = (cdir != 0) ? m_count - 1 : m_count + 1;
            end else begin
                m_tc = 1;
                if (mode == 1) begin
                    m_done = 1;
                end else if (mode == 2) begin
                    m_bdir = 1 - m_bdir;
                    if (mx == 0)        m_count = 0;
                    else if (cdir != 0) m_count = 1;
                    else                m_count = mx - 1;
                end else begin
                    m_count = (cdir != 0) ? mx : 0;
                end
            end
        end
    endfunction

    task automatic test_reset;
        bus.en = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b1; bus.mode = 2'b00; bus.max_val = 8'd255;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bus.count, bus.tc, bus.done, bus.cur_dir} !== {8'd255, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got count=%0d tc=%b done=%b cur_dir=%b, want 255 0 0 1",
                     bus.count, bus.tc, bus.done, bus.cur_dir);
        end
        bus.en = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        bus.en = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            e = 8'((255 - k + 512) % 256);
            n_tests++;
            if ({bus.count, bus.tc} !== {e, (k == 256)}) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got count=%0d tc=%b, want %0d %b",
                         k, bus.count, bus.tc, e, (k == 256));
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_oneshot;
        logic [7:0] ec [6] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       et [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.mode = 2'b01; bus.dir = 1'b1; bus.max_val = 8'd255;
        bus.load = 1'b1; bus.load_val = 8'd3; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        n_tests++;
        if ({bus.count, bus.done} !== {8'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL oneshot_load: got count=%0d done=%b, want 3 0", bus.count, bus.done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if ({bus.count, bus.tc, bus.done} !== {ec[i], et[i], ed[i]}) begin
                n_fail++;
                $display("FAIL oneshot_step%0d: got count=%0d tc=%b done=%b, want %0d %b %b",
                         i, bus.count, bus.tc, bus.done, ec[i], et[i], ed[i]);
            end
        end
        bus.load = 1'b1; bus.load_val = 8'd5;
        tick();
        bus.load = 1'b0; bus.en = 1'b0;
        n_tests++;
        if ({bus.count, bus.done} !== {8'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL oneshot_reload: got count=%0d done=%b, want 5 0", bus.count, bus.done);
        end
    endtask

    task automatic test_bounce;
        logic [7:0] ec [7] = '{8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
        logic       et [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       ecd[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.mode = 2'b10; bus.dir = 1'b0; bus.max_val = 8'd3;
        bus.load = 1'b1; bus.load_val = 8'd1; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.dir  = 1'b1;   // ignored in bounce mode after load
        n_tests++;
        if ({bus.count, bus.cur_dir} !== {8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bounce_load: got count=%0d cur_dir=%b, want 1 0", bus.count, bus.cur_dir);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++;
            if ({bus.count, bus.tc, bus.cur_dir} !== {ec[i], et[i], ecd[i]}) begin
                n_fail++;
                $display("FAIL bounce_step%0d: got count=%0d tc=%b cur_dir=%b, want %0d %b %b",
                         i, bus.count, bus.tc, bus.cur_dir, ec[i], et[i], ecd[i]);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_clamp;
        bus.mode = 2'b00; bus.dir = 1'b0; bus.max_val = 8'd10;
        bus.load = 1'b1; bus.load_val = 8'd200; bus.en = 1'b0;
        tick();
        bus.load = 1'b0;
        n_tests++;
        if (bus.count !== 8'd10) begin
            n_fail++;
            $display("FAIL clamp_load: got count=%0d, want 10", bus.count);
        end
        bus.en = 1'b1;
        tick();
        n_tests++;
        if ({bus.count, bus.tc} !== {8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clamp_upwrap: got count=%0d tc=%b, want 0 1", bus.count, bus.tc);
        end
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'd7;
        tick();
        bus.load = 1'b0; bus.max_val = 8'd4; bus.en = 1'b1;
        tick();
        n_tests++;
        if ({bus.count, bus.tc} !== {8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clamp_lowered_max: got count=%0d tc=%b, want 0 1", bus.count, bus.tc);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_async_reset;
        bit seen;
        bus.mode = 2'b01; bus.dir = 1'b0; bus.max_val = 8'd37;
        bus.load = 1'b1; bus.load_val = 8'd37; bus.en = 1'b0;
        tick();
        bus.load = 1'b0; bus.en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = (bus.done === 1'b1);
        end
        bus.en = 1'b0;
        n_tests++;
        if ({bus.count, bus.tc, bus.done} !== {8'd37, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_pre: got count=%0d tc=%b done=%b, want 37 1 1",
                     bus.count, bus.tc, bus.done);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.count, bus.tc, bus.done} !== {8'd255, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d tc=%b done=%b, want 255 0 0",
                     bus.count, bus.tc, bus.done);
        end
        #1 rst = 1'b0;
        bus.mode = 2'b00; bus.dir = 1'b1; bus.max_val = 8'd255;
        bus.load = 1'b1; bus.load_val = 8'd9; bus.en = 1'b1;
        tick();
        bus.load = 1'b0; bus.en = 1'b0;
        n_tests++;
        if (bus.count !== 8'd9) begin
            n_fail++;
            $display("FAIL load_over_en: got count=%0d, want 9", bus.count);
        end
    endtask

`ifdef UDC_PRESCALE_EN
    task automatic test_prescale;
        int         enabled;
        logic [7:0] e;
        bus.mode = 2'b00; bus.dir = 1'b1; bus.max_val = 8'd255;
        bus.load = 1'b1; bus.load_val = 8'd10; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        enabled = 0;
        for (int i = 0; i < 20; i++) begin
            bus.en = (i >= 8 && i < 11) ? 1'b0 : 1'b1;
            if (bus.en) enabled++;
            tick();
            e = 8'(10 - enabled / PS);
            n_tests++;
            if (bus.count !== e) begin
                n_fail++;
                $display("FAIL prescale_cyc%0d: got count=%0d, want %0d", i, bus.count, e);
            end
        end
        bus.en = 1'b0;
    endtask
`endif

    task automatic test_random;
        int ld, ldv, en, dir, mode, mx;
        logic [7:0] ec;
        logic       ecd;
        bus.mode = 2'b00; bus.dir = 1'b1; bus.max_val = 8'd200;
        bus.load = 1'b1; bus.load_val = 8'd100; bus.en = 1'b0;
        model_edge(1, 100, 0, 1, 0, 200);
        tick();
        mx = 200;
        for (int i = 0; i < 600; i++) begin
            ld   = ($urandom_range(0, 15) == 0) ? 1 : 0;
            ldv  = $urandom_range(0, 255);
            en   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            dir  = ($urandom_range(0, 7) == 0) ? 1 - int'(bus.dir) : int'(bus.dir);
            mode = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : int'(bus.mode);
            if ($urandom_range(0, 19) == 0)
                mx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            bus.load = 1'(ld); bus.load_val = 8'(ldv); bus.en = 1'(en);
            bus.dir = 1'(dir); bus.mode = 2'(mode); bus.max_val = 8'(mx);
            model_edge(ld, ldv, en, dir, mode, mx);
            tick();
            ec  = 8'(m_count);
            ecd = (mode == 2) ? 1'(m_bdir) : 1'(dir);
            n_tests++;
            if ({bus.count, bus.tc, bus.done, bus.cur_dir} !== {ec, 1'(m_tc), 1'(m_done), ecd}) begin
                n_fail++;
                $display("FAIL random%0d: got count=%0d tc=%b done=%b cur_dir=%b, want %0d %0d %0d %b",
                         i, bus.count, bus.tc, bus.done, bus.cur_dir, ec, m_tc, m_done, ecd);
            end
        end
        bus.load = 1'b0; bus.en = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b0; bus.mode = 2'b00; bus.max_val = '0;
        m_count = 255; m_tc = 0; m_done = 0; m_bdir = 1; m_ps = 0;
        test_reset();
`ifndef UDC_PRESCALE_EN
        test_wrap();
        test_oneshot();
        test_bounce();
        test_clamp();
`endif
        test_async_reset();
`ifdef UDC_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
